// File: rtl/mc_control_fsm.sv
// Main control FSM for the multicycle CPU.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It decodes the IR opcode and drives
// every datapath select and write-enable. It also counts retired instructions.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   opcode              IR[31:26], sampled only in DECODE and MEMADR
//   mem_ready           memory handshake; used only in FETCH, MEMRD and MEMWR
//   PCWrite..PCSource   datapath control (strobes, enables and mux selects)
//   illegal_op          high during DECODE when the opcode is unsupported
//   state               current FSM state, for debug
//   instr_cnt           retired-instruction counter, wraps modulo 2^CNT_W
module mc_control_fsm #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtypeEx = 4'd6,
        StRtypeWb = 4'd7,
        StBeq     = 4'd8,
        StJump    = 4'd9,
        StAddiEx  = 4'd10,
        StAddiWb  = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instr_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StFetch;
            instr_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            // An instruction retires whenever control returns to FETCH from elsewhere.
            if ((state_d == StFetch) && (state_q != StFetch)) begin
                instr_cnt_q <= instr_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d     = StFetch;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        illegal_op  = 1'b0;
        // Under reset every output stays at its zero default; the register ignores state_d.
        if (!rst) begin
            unique case (state_q)
                StFetch: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                    state_d = mem_ready ? StDecode : StFetch;
                end
                StDecode: begin
                    // Branch target computed speculatively into ALUOut.
                    ALUSrcB = 2'b11;
                    unique case (opcode)
                        OpLw, OpSw: state_d = StMemAdr;
                        OpRtype:    state_d = StRtypeEx;
                        OpBeq:      state_d = StBeq;
                        OpJ:        state_d = StJump;
                        OpAddi:     state_d = StAddiEx;
                        default: begin
                            illegal_op = 1'b1;
                            state_d    = StFetch;
                        end
                    endcase
                end
                StMemAdr: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    // Only lw/sw reach here, so anything other than lw is a store.
                    state_d = (opcode == OpLw) ? StMemRd : StMemWr;
                end
                StMemRd: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    state_d = mem_ready ? StMemWb : StMemRd;
                end
                StMemWb: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                    state_d  = StFetch;
                end
                StMemWr: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    state_d  = mem_ready ? StFetch : StMemWr;
                end
                StRtypeEx: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                    state_d = StRtypeWb;
                end
                StRtypeWb: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                    state_d  = StFetch;
                end
                StBeq: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    state_d     = StFetch;
                end
                StJump: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                    state_d  = StFetch;
                end
                StAddiEx: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    state_d = StAddiWb;
                end
                StAddiWb: begin
                    RegWrite = 1'b1;
                    state_d  = StFetch;
                end
                default: state_d = StFetch;
            endcase
        end
    end

    assign state     = state_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: a table of per-cycle {inputs, expected outputs} records is
// pushed to a scoreboard queue as each row is driven and checked on the falling edge.
// A second instance with a 4-bit counter shares the stimulus to exercise counter wrap.
module tb_mc_control_fsm;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic        mem_ready;

    logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic [31:0] instr_cnt;

    logic        pc_write4, pc_write_cond4, iord4, mem_read4, mem_write4, ir_write4;
    logic        mem_to_reg4, reg_dst4, reg_write4, alu_src_a4, illegal_op4;
    logic [1:0]  alu_src_b4, alu_op4, pc_source4;
    logic [3:0]  state4;
    logic [3:0]  instr_cnt4;

    mc_control_fsm #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(pc_write), .PCWriteCond(pc_write_cond), .IorD(iord), .MemRead(mem_read),
        .MemWrite(mem_write), .IRWrite(ir_write), .MemtoReg(mem_to_reg), .RegDst(reg_dst),
        .RegWrite(reg_write), .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b), .ALUOp(alu_op),
        .PCSource(pc_source), .illegal_op(illegal_op), .state(state), .instr_cnt(instr_cnt)
    );

    mc_control_fsm #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(pc_write4), .PCWriteCond(pc_write_cond4), .IorD(iord4),
        .MemRead(mem_read4), .MemWrite(mem_write4), .IRWrite(ir_write4),
        .MemtoReg(mem_to_reg4), .RegDst(reg_dst4), .RegWrite(reg_write4),
        .ALUSrcA(alu_src_a4), .ALUSrcB(alu_src_b4), .ALUOp(alu_op4),
        .PCSource(pc_source4), .illegal_op(illegal_op4), .state(state4),
        .instr_cnt(instr_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle layout:
    // PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite ALUSrcA
    // ALUSrcB[1:0] ALUOp[1:0] PCSource[1:0] illegal_op
    logic [16:0] act, act4;
    assign act  = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                   reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};
    assign act4 = {pc_write4, pc_write_cond4, iord4, mem_read4, mem_write4, ir_write4,
                   mem_to_reg4, reg_dst4, reg_write4, alu_src_a4, alu_src_b4, alu_op4,
                   pc_source4, illegal_op4};

    localparam logic [16:0] Z   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] FR  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] FW  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] DE  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] DI  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [16:0] MA  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] MRD = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] MWB = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] MWR = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] REX = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] RWB = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] BQ  = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] JP  = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] AEX = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] AWB = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
    localparam logic [5:0] ILL1 = 6'b111111, ILL2 = 6'b000011;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] out;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   row   = 0;

    task automatic add(input logic r, input logic [5:0] op, input logic rdy,
                       input logic [3:0] st, input logic [16:0] out, input logic [31:0] cnt);
        vec_t v;
        v.rst = r; v.op = op; v.rdy = rdy; v.st = st; v.out = out; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int r, input logic [31:0] a,
                         input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s row %0d: got %h expected %h", name, r, a, e);
        end
    endtask

    // Scoreboard consumer: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            vec_t e;
            e = exp_q.pop_front();
            check("state",      row, {28'd0, state},      {28'd0, e.st});
            check("outputs",    row, {15'd0, act},        {15'd0, e.out});
            check("instr_cnt",  row, instr_cnt,           e.cnt);
            check("state4",     row, {28'd0, state4},     {28'd0, e.st});
            check("outputs4",   row, {15'd0, act4},       {15'd0, e.out});
            check("instr_cnt4", row, {28'd0, instr_cnt4}, {28'd0, e.cnt[3:0]});
            row++;
        end
    end

    initial begin
        // Reset held, outputs forced low even though FETCH would assert strobes.
        add(1, RT,   1, 0,  Z,   0);
        // lw: 0,1,2,3,4,0
        add(0, LW,   1, 0,  FR,  0);
        add(0, LW,   1, 1,  DE,  0);
        add(0, LW,   1, 2,  MA,  0);
        add(0, LW,   1, 3,  MRD, 0);
        add(0, LW,   1, 4,  MWB, 0);
        // j: 0,1,9
        add(0, JMP,  1, 0,  FR,  1);
        add(0, JMP,  1, 1,  DE,  1);
        add(0, JMP,  1, 9,  JP,  1);
        // beq: 0,1,8
        add(0, BEQ,  1, 0,  FR,  2);
        add(0, BEQ,  1, 1,  DE,  2);
        add(0, BEQ,  1, 8,  BQ,  2);
        // R-type: 0,1,6,7
        add(0, RT,   1, 0,  FR,  3);
        add(0, RT,   1, 1,  DE,  3);
        add(0, RT,   1, 6,  REX, 3);
        add(0, RT,   1, 7,  RWB, 3);
        // sw with FETCH stall, then MEMWR stall; mem_ready ignored in DECODE/MEMADR
        add(0, SW,   0, 0,  FW,  4);
        add(0, SW,   0, 0,  FW,  4);
        add(0, SW,   0, 0,  FW,  4);
        add(0, SW,   1, 0,  FR,  4);
        add(0, SW,   0, 1,  DE,  4);
        add(0, SW,   0, 2,  MA,  4);
        add(0, SW,   0, 5,  MWR, 4);
        add(0, SW,   0, 5,  MWR, 4);
        add(0, SW,   0, 5,  MWR, 4);
        add(0, SW,   1, 5,  MWR, 4);
        // addi: 0,1,10,11
        add(0, ADDI, 1, 0,  FR,  5);
        add(0, ADDI, 1, 1,  DE,  5);
        add(0, ADDI, 1, 10, AEX, 5);
        add(0, ADDI, 1, 11, AWB, 5);
        // Two unsupported opcodes: one-cycle illegal_op, still retire
        add(0, ILL1, 1, 0,  FR,  6);
        add(0, ILL1, 1, 1,  DI,  6);
        add(0, ILL2, 1, 0,  FR,  7);
        add(0, ILL2, 1, 1,  DI,  7);
        // lw interrupted by reset while waiting in MEMRD: no writeback, counter cleared
        add(0, LW,   1, 0,  FR,  8);
        add(0, LW,   1, 1,  DE,  8);
        add(0, LW,   0, 2,  MA,  8);
        add(0, LW,   0, 3,  MRD, 8);
        add(1, LW,   1, 3,  Z,   8);
        add(0, LW,   0, 0,  FW,  0);
        // 16 back-to-back addi: the 4-bit counter wraps 15 -> 0
        for (int i = 0; i < 16; i++) begin
            add(0, ADDI, 1, 0,  FR,  i);
            add(0, ADDI, 1, 1,  DE,  i);
            add(0, ADDI, 1, 10, AEX, i);
            add(0, ADDI, 1, 11, AWB, i);
        end
        add(0, ADDI, 0, 0, FW, 16);

        rst       = 1'b1;
        opcode    = RT;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            rst       = tbl[i].rst;
            opcode    = tbl[i].op;
            mem_ready = tbl[i].rdy;
            exp_q.push_back(tbl[i]);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
